// File: rtl/sd_cmd_ctrl.sv
// SD-bus CMD line sequencer: sends one 48-bit command frame, then optionally receives a 48/136-bit response and checks its CRC7.
// Optional response-index check is built when SD_CMD_IDX_CHECK_EN is defined; otherwise idx_err is tied 0.
module sd_cmd_ctrl #(
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sd_stb,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         cmd_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic         crc_err,
  output logic         timeout_err,
  output logic         idx_err,
  output logic         cmd_out,
  output logic         cmd_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_GAP,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [39:0]    tx_sr_q, tx_sr_d;
  logic [6:0]     tx_crc_q, tx_crc_d;
  logic [6:0]     rx_crc_q, rx_crc_d;
  logic [1:0]     type_q, type_d;
  logic [127:0]   resp_q, resp_d;
  logic           crc_err_q, crc_err_d;
  logic           timeout_err_q, timeout_err_d;
  logic           cmd_out_q, cmd_out_d;
  logic           cmd_oe_q, cmd_oe_d;

  logic           launch;
  logic           rx_last;
  logic           rx_end;
  logic           rx_in_crc;
  logic [127:0]   rx_shift;

  // CRC7 (x^7 + x^3 + 1) serial update, one bit per call.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign launch   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign rx_shift = {resp_q[126:0], cmd_in};
  assign rx_last  = (type_q == 2'b10) ? (cnt_q == 8'd135) : (cnt_q == 8'd47);
  assign rx_end   = (state_q == S_RX) && sd_stb && rx_last;
  // cnt_q is the index of the bit being received (start bit = 0); CRC skips the R2 header.
  assign rx_in_crc = (type_q == 2'b10) ? ((cnt_q >= 8'd8) && (cnt_q <= 8'd127))
                                       : (cnt_q <= 8'd39);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_sr_d       = tx_sr_q;
    tx_crc_d      = tx_crc_q;
    rx_crc_d      = rx_crc_q;
    type_d        = type_q;
    resp_d        = resp_q;
    crc_err_d     = crc_err_q;
    timeout_err_d = timeout_err_q;
    cmd_out_d     = cmd_out_q;
    cmd_oe_d      = cmd_oe_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (launch) begin
          tx_sr_d       = {2'b01, cmd_index, cmd_arg};
          type_d        = resp_type;
          tx_crc_d      = '0;
          rx_crc_d      = '0;
          resp_d        = '0;
          crc_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          state_d       = S_TX;
        end
      end

      S_TX: begin
        if (sd_stb) begin
          cnt_d    = cnt_q + 8'd1;
          cmd_oe_d = 1'b1;
          if (cnt_q < 8'd40) begin
            cmd_out_d = tx_sr_q[39];
            tx_sr_d   = {tx_sr_q[38:0], 1'b0};
            tx_crc_d  = crc7_step(tx_crc_q, tx_sr_q[39]);
          end else if (cnt_q < 8'd47) begin
            // The finished CRC is shifted out of its own register MSB-first.
            cmd_out_d = tx_crc_q[6];
            tx_crc_d  = {tx_crc_q[5:0], 1'b0};
          end else if (cnt_q == 8'd47) begin
            cmd_out_d = 1'b1;
          end else begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            cnt_d     = '0;
            state_d   = (type_q == 2'b00) ? S_GAP : S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (sd_stb) begin
          if (!cmd_in) begin
            resp_d   = rx_shift;
            cnt_d    = 8'd1;
            rx_crc_d = (type_q == 2'b10) ? rx_crc_q : crc7_step(rx_crc_q, 1'b0);
            state_d  = S_RX;
          end else if (cnt_q == 8'(RESP_TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            cnt_d         = '0;
            state_d       = S_GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_RX: begin
        if (sd_stb) begin
          resp_d = rx_shift;
          if (rx_in_crc) begin
            rx_crc_d = crc7_step(rx_crc_q, cmd_in);
          end
          if (rx_last) begin
            crc_err_d = (type_q != 2'b11) && (rx_shift[7:1] != rx_crc_q);
            cnt_d     = '0;
            state_d   = S_GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_GAP: begin
        if (sd_stb) begin
          if (cnt_q == 8'(GAP_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tx_sr_q       <= '0;
      tx_crc_q      <= '0;
      rx_crc_q      <= '0;
      type_q        <= '0;
      resp_q        <= '0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cmd_out_q     <= 1'b1;
      cmd_oe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_sr_q       <= tx_sr_d;
      tx_crc_q      <= tx_crc_d;
      rx_crc_q      <= rx_crc_d;
      type_q        <= type_d;
      resp_q        <= resp_d;
      crc_err_q     <= crc_err_d;
      timeout_err_q <= timeout_err_d;
      cmd_out_q     <= cmd_out_d;
      cmd_oe_q      <= cmd_oe_d;
    end
  end

`ifdef SD_CMD_IDX_CHECK_EN
  logic [5:0] idx_q, idx_d;
  logic       idx_err_q, idx_err_d;

  always_comb begin
    idx_d     = idx_q;
    idx_err_d = idx_err_q;
    if (launch) begin
      idx_d     = cmd_index;
      idx_err_d = 1'b0;
    end else if (rx_end) begin
      idx_err_d = (type_q == 2'b01) && (rx_shift[45:40] != idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      idx_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign idx_err = idx_err_q;
`else
  assign idx_err = 1'b0;
`endif

  assign busy        = (state_q == S_TX) || (state_q == S_WAIT) ||
                       (state_q == S_RX) || (state_q == S_GAP);
  assign done        = (state_q == S_DONE);
  assign resp        = resp_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = timeout_err_q;
  assign cmd_out     = cmd_out_q;
  assign cmd_oe      = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Self-checking bench for sd_cmd_ctrl: directed and randomized command/response transactions
// compared against a polynomial-division CRC7 reference model.
module tb_sd_cmd_ctrl;
  localparam int unsigned RESP_TIMEOUT = 64;
  localparam int unsigned GAP_CYCLES   = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sd_stb;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         cmd_in;
  logic         busy, done, crc_err, timeout_err, idx_err, cmd_out, cmd_oe;
  logic [127:0] resp;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int unsigned stb_gap = 0;

  sd_cmd_ctrl #(
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sd_stb     (sd_stb),
    .start      (start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp_type  (resp_type),
    .cmd_in     (cmd_in),
    .busy       (busy),
    .done       (done),
    .resp       (resp),
    .crc_err    (crc_err),
    .timeout_err(timeout_err),
    .idx_err    (idx_err),
    .cmd_out    (cmd_out),
    .cmd_oe     (cmd_oe)
  );

  always #5 clk = ~clk;

  // Irregular SD clock-enable: strobes 2..5 clks apart.
  initial begin
    sd_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (stb_gap == 0) begin
        sd_stb  = 1'b1;
        stb_gap = $urandom_range(1, 4);
      end else begin
        sd_stb  = 1'b0;
        stb_gap = stb_gap - 1;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  // Reference CRC7: remainder of msg(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int unsigned nbits);
    logic [134:0] r;
    r = {7'b0, msg} << 7;
    for (int i = int'(nbits) + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_div({88'b0, 2'b01, idx, arg}, 40), 1'b1};
  endfunction

  function automatic logic [47:0] mk_r48(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b00, idx, arg, crc7_div({88'b0, 2'b00, idx, arg}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk_r2(input logic [119:0] payload);
    return {2'b00, 6'h3F, payload, crc7_div({8'b0, payload}, 120), 1'b1};
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_stb();
    do @(posedge clk); while (sd_stb !== 1'b1);
    #1;
  endtask

  // One full transaction. delay >= RESP_TIMEOUT means no response is ever driven.
  task automatic run_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input int unsigned delay,
                         input logic [135:0] rframe, input logic [47:0] exp_frame,
                         input int unsigned abort_at, input logic mid_start);
    logic [47:0]  txf;
    logic         oe_all;
    logic         early;
    logic         is_to;
    logic [127:0] exp_resp;
    logic         exp_crc;
    logic         exp_idx;
    int unsigned  nbits;
    int           d0;

    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; resp_type = typ; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
    check({name, "/busy_after_start"}, busy, 1'b1);
    check({name, "/errs_cleared"}, {crc_err, timeout_err, idx_err}, 3'b000);

    oe_all = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (mid_start && i == 10) start = 1'b1;
      if (mid_start && i == 12) start = 1'b0;
      next_stb();
      txf[47 - i] = cmd_out;
      oe_all = oe_all & cmd_oe;
    end
    check({name, "/tx_frame"}, txf, exp_frame);
    check({name, "/tx_oe"}, oe_all, 1'b1);
    next_stb();
    check({name, "/tx_release"}, {cmd_oe, cmd_out}, 2'b01);

    d0    = done_cnt;
    is_to = (typ != 2'b00) && (delay >= RESP_TIMEOUT);
    nbits = (typ == 2'b10) ? 136 : 48;
    if (typ != 2'b00) begin
      if (is_to) begin
        cmd_in = 1'b1;
        for (int k = 0; k < int'(RESP_TIMEOUT); k++) next_stb();
      end else begin
        for (int k = 0; k < int'(delay); k++) begin cmd_in = 1'b1; next_stb(); end
        for (int b = 0; b < int'(nbits); b++) begin
          cmd_in = rframe[nbits - 1 - b];
          next_stb();
          if (abort_at != 0 && b + 1 == int'(abort_at)) begin
            #2 rst_n = 1'b0;
            #1;
            check({name, "/abort_outputs"}, {busy, done, cmd_oe, cmd_out}, 4'b0001);
            check({name, "/abort_resp"}, resp, 128'b0);
            cmd_in = 1'b1;
            repeat (5) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            check({name, "/abort_no_done"}, done_cnt, d0);
            check({name, "/abort_idle"}, {busy, cmd_oe}, 2'b00);
            return;
          end
        end
        cmd_in = 1'b1;
      end
    end

    early = 1'b0;
    for (int g = 0; g < int'(GAP_CYCLES) - 1; g++) begin
      next_stb();
      if (done_cnt != d0 || cmd_oe !== 1'b0) early = 1'b1;
    end
    check({name, "/gap_quiet"}, early, 1'b0);
    next_stb();
    check({name, "/done_busy"}, {done, busy}, 2'b10);
    @(posedge clk); #1;
    check({name, "/done_single"}, {done, done_cnt - d0}, {1'b0, 32'd1});

    exp_resp = '0; exp_crc = 1'b0; exp_idx = 1'b0;
    if (!is_to && typ != 2'b00) begin
      if (typ == 2'b10) begin
        exp_resp = rframe[127:0];
        exp_crc  = crc7_div({8'b0, rframe[127:8]}, 120) != rframe[7:1];
      end else begin
        exp_resp = {80'b0, rframe[47:0]};
        exp_crc  = (typ == 2'b01) && (crc7_div({88'b0, rframe[47:8]}, 40) != rframe[7:1]);
      end
`ifdef SD_CMD_IDX_CHECK_EN
      exp_idx = (typ == 2'b01) && (rframe[45:40] != idx);
`endif
    end
    check({name, "/resp"}, resp, exp_resp);
    check({name, "/crc_err"}, crc_err, exp_crc);
    check({name, "/timeout_err"}, timeout_err, is_to);
    check({name, "/idx_err"}, idx_err, exp_idx);
  endtask

  initial begin
    logic [47:0]  r8;
    logic [135:0] r2;
    logic [119:0] pl;
    logic [5:0]   ridx, ix;
    logic [31:0]  ag;
    logic [1:0]   ty;
    logic [135:0] rf;
    int unsigned  dl;

    rst_n = 1'b0; start = 1'b0; cmd_in = 1'b1;
    cmd_index = '0; cmd_arg = '0; resp_type = '0;
    repeat (4) @(posedge clk);
    #1;
    check("reset/outputs", {busy, done, crc_err, timeout_err, idx_err, cmd_out, cmd_oe}, 7'b0000010);
    check("reset/resp", resp, 128'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_txn("cmd0", 6'd0, 32'h0, 2'b00, 0, '0, 48'h400000000095, 0, 1'b0);

    r8 = 48'h08000001AA13;
    run_txn("cmd8", 6'd8, 32'h000001AA, 2'b01, 2, {88'b0, r8}, 48'h48000001AA87, 0, 1'b0);
    r8 = r8 ^ 48'h000000100000;
    run_txn("cmd8_flip", 6'd8, 32'h000001AA, 2'b01, 2, {88'b0, r8}, 48'h48000001AA87, 0, 1'b0);

    run_txn("cmd17_to", 6'd17, 32'h0, 2'b01, RESP_TIMEOUT, '0, 48'h510000000055, 0, 1'b0);

    r8 = {2'b00, 6'h3F, 32'h80FF8000, 8'hFF};
    run_txn("cmd41_r3", 6'd41, 32'h40FF8000, 2'b11, 1, {88'b0, r8}, mk_cmd(6'd41, 32'h40FF8000), 0, 1'b0);

    pl = {$urandom, $urandom, $urandom, 24'($urandom)};
    r2 = mk_r2(pl);
    run_txn("cmd2_r2", 6'd2, 32'h0, 2'b10, 3, r2, mk_cmd(6'd2, 32'h0), 0, 1'b0);
    run_txn("cmd2_abort", 6'd2, 32'h0, 2'b10, 3, r2, mk_cmd(6'd2, 32'h0), 60, 1'b0);

    for (int t = 0; t < 10; t++) begin
      ix = 6'($urandom); ag = $urandom; ty = 2'($urandom);
      dl = ($urandom_range(0, 5) == 0) ? RESP_TIMEOUT : $urandom_range(0, 12);
      ridx = ($urandom_range(0, 1) == 0) ? ix : 6'($urandom);
      if (ty == 2'b10) begin
        pl = {$urandom, $urandom, $urandom, 24'($urandom)};
        rf = mk_r2(pl);
      end else begin
        rf = {88'b0, mk_r48(ridx, $urandom)};
      end
      if ($urandom_range(0, 2) == 0) rf[$urandom_range(1, (ty == 2'b10) ? 127 : 46)] ^= 1'b1;
      run_txn($sformatf("rand%0d", t), ix, ag, ty, dl, rf, mk_cmd(ix, ag), 0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_ctrl.md
Name: sd_cmd_ctrl

Overview:
- Sequences one SD-bus command transaction on the CMD line.
- Transmit side: serializes a 48-bit command frame (start, transmission bit, index, argument, CRC7, end bit).
- Receive side: waits for an optional R1/R3/R2-style response, captures it, checks its CRC7 and reports status.
- Sits between the cartridge's SD host logic and the CMD pad. Uses two internal CRC7 shift instances (x^7+x^3+1, zero seed): one for transmit, one for receive. Bit timing comes from an external SD clock-enable strobe.

Parameters:
- RESP_TIMEOUT, 64, max sd_stb periods waiting for a response start bit (NCR) before timeout.
- GAP_CYCLES, 8, idle sd_stb periods with CMD released after the transaction, before done.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sd_stb  input  1  one-clk strobe per SD clock period; all CMD drive/sample happens on it
- start  input  1  begin transaction; honoured only when busy=0
- cmd_index  input  6  command index, latched on start
- cmd_arg  input  32  argument, latched on start
- resp_type  input  2  00 none, 01 48-bit with CRC (R1/R6/R7), 10 136-bit (R2), 11 48-bit without CRC check (R3)
- busy  output  1  high from the cycle after start through done
- done  output  1  one-clk pulse at end of transaction
- resp  output  128  captured response
- crc_err  output  1  response CRC mismatch; valid with done
- timeout_err  output  1  no response start bit within RESP_TIMEOUT; valid with done
- idx_err  output  1  response index mismatch (optional feature); valid with done
- cmd_out  output  1  CMD pad drive value
- cmd_oe  output  1  CMD pad output enable

Behaviour:
- Reset values: busy=0, done=0, resp=0, all err=0, cmd_out=1, cmd_oe=0, state IDLE, both CRCs 0. Reset mid-transaction aborts immediately: CMD is released and no done pulse is issued.
- IDLE:
  - start=1 latches index, arg and type; clears err flags and both CRCs; busy goes high the next clk; state becomes TX.
  - start while busy is ignored.
- TX:
  - On each sd_stb, drive the next frame bit MSB-first with cmd_oe=1.
  - Bit order: 0, 1, index[5:0], arg[31:0], crc[6:0], 1.
  - Bits 47..8 are fed into the TX CRC as they are driven. Bits 7..1 come from the CRC register. Exactly 48 strobes are driven.
  - On the strobe after the end bit, cmd_oe=0 and cmd_out=1. Next state is GAP if type=00, else WAIT.
- WAIT:
  - Sample cmd_in on each sd_stb, counting strobes.
  - cmd_in=0 is the start bit: go to RX with 1 bit received.
  - RESP_TIMEOUT strobes without a start bit: set timeout_err and go to GAP.
- RX:
  - Shift cmd_in into resp LSB-first-in, so the final layout is MSB-oldest.
  - Total bits including the start bit: 48 for types 01/11, 136 for type 10.
  - Types 01/11: resp[47:0] holds the full frame; resp[127:48]=0. The RX CRC covers frame bits 47..8.
  - Type 10: resp[127:0] holds frame bits 127..0 (CID/CSD[127:1] plus end bit); the 8 header bits are dropped. The RX CRC covers frame bits 127..8.
  - After the last bit: crc_err = (received bits 7..1 != RX CRC) for types 01/10, forced 0 for type 11. Then go to GAP.
- GAP: GAP_CYCLES strobes with CMD released, then go to DONE.
- DONE: done=1 for one clk, busy=0 the same cycle, return to IDLE. resp and err flags hold until the next start.
- Gaps in sd_stb: no state advances between strobes. sd_stb coincident with start is ignored; TX begins on the next strobe.

Optional Feature:
- Macro SD_CMD_IDX_CHECK_EN.
- Defined: for type 01, idx_err = (resp[45:40] != latched cmd_index), set at end of RX. It is 0 for other types and on timeout.
- Undefined: the comparator is not built and idx_err is tied 0.

Test Plan:
- CMD0, arg 0, type 00 -> cmd_out bitstream 0x400000000095 over 48 strobes, then 8 released strobes, done with no errors.
- CMD8, arg 0x000001AA, type 01; bench returns 0x08000001AA13 after 2 idle strobes -> frame 0x48000001AA87 sent; resp[47:0]=0x08000001AA13, crc_err=0, idx_err=0.
- Same as previous, but one response arg bit flipped -> crc_err=1.
- CMD17, arg 0, type 01, cmd_in held 1 -> frame 0x510000000055; timeout_err=1 after 64 strobes in WAIT; done after 8-strobe gap.
- CMD41, type 11, R3 with arbitrary CRC byte 0xFF -> crc_err=0.
- CMD2, type 10, 136-bit response with valid CRC -> resp[127:0] matches payload, crc_err=0. Assert rst_n=0 mid-RX on a rerun -> cmd_oe=0, busy=0, no done pulse.
